// File: rtl/mem_port_arbiter_if.sv
// Bus between the pipeline requesters (IF fetch, MEM load/store) and the
// unified-memory port arbiter.
interface mem_port_arbiter_if;
  // Handshake: a requester raises Req_x and holds it until it sees Ack_x.
  // Ack_x is a one-cycle pulse in the last access cycle. Gnt_x marks ownership
  // for the whole access. We_MEM is sampled only at grant.
  logic Req_IF;
  logic Req_MEM;
  logic We_MEM;
  logic Mux_Sel;
  logic Mem_En;
  logic Mem_We;
  logic Gnt_IF;
  logic Gnt_MEM;
  logic Ack_IF;
  logic Ack_MEM;
  logic Busy;

  modport master (
    output Req_IF, Req_MEM, We_MEM,
    input  Mux_Sel, Mem_En, Mem_We, Gnt_IF, Gnt_MEM, Ack_IF, Ack_MEM, Busy
  );

  modport slave (
    input  Req_IF, Req_MEM, We_MEM,
    output Mux_Sel, Mem_En, Mem_We, Gnt_IF, Gnt_MEM, Ack_IF, Ack_MEM, Busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default: MEM wins ties).
module mem_port_arbiter #(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  mem_port_arbiter_if.slave   bus,
  output logic                fsm_state
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       mux_sel_q, mux_sel_d;
  logic       mem_en_q, mem_en_d;
  logic       mem_we_q, mem_we_d;
  logic       gnt_if_q, gnt_if_d;
  logic       gnt_mem_q, gnt_mem_d;
  logic       ack_if_q, ack_if_d;
  logic       ack_mem_q, ack_mem_d;
  logic       busy_q, busy_d;
  logic       any_req;
  logic       win_mem;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = MEM was served last; ties go to whichever side was not.
  logic last_mem_q, last_mem_d;

  always_comb begin
    win_mem = bus.Req_MEM & (~bus.Req_IF | ~last_mem_q);
  end
`else
  always_comb begin
    win_mem = bus.Req_MEM;
  end
`endif

  assign any_req = bus.Req_IF | bus.Req_MEM;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mux_sel_d = mux_sel_q;
    mem_en_d  = 1'b0;
    mem_we_d  = 1'b0;
    gnt_if_d  = 1'b0;
    gnt_mem_d = 1'b0;
    ack_if_d  = 1'b0;
    ack_mem_d = 1'b0;
    busy_d    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_mem_d = last_mem_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d   = ACCESS;
          cnt_d     = CNT_W'(LATENCY - 1);
          mux_sel_d = win_mem;
          mem_en_d  = 1'b1;
          mem_we_d  = win_mem & bus.We_MEM;
          gnt_if_d  = ~win_mem;
          gnt_mem_d = win_mem;
          busy_d    = 1'b1;
          // A single-cycle access acknowledges in its only cycle.
          if (LATENCY == 1) begin
            ack_if_d  = ~win_mem;
            ack_mem_d = win_mem;
          end
`ifdef ARB_ROUND_ROBIN_EN
          last_mem_d = win_mem;
`endif
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d     = cnt_q - 1'b1;
          mem_en_d  = mem_en_q;
          mem_we_d  = mem_we_q;
          gnt_if_d  = gnt_if_q;
          gnt_mem_d = gnt_mem_q;
          busy_d    = busy_q;
          if (cnt_q == CNT_W'(1)) begin
            ack_if_d  = gnt_if_q;
            ack_mem_d = gnt_mem_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mux_sel_q <= 1'b0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      gnt_if_q  <= 1'b0;
      gnt_mem_q <= 1'b0;
      ack_if_q  <= 1'b0;
      ack_mem_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_mem_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mux_sel_q <= mux_sel_d;
      mem_en_q  <= mem_en_d;
      mem_we_q  <= mem_we_d;
      gnt_if_q  <= gnt_if_d;
      gnt_mem_q <= gnt_mem_d;
      ack_if_q  <= ack_if_d;
      ack_mem_q <= ack_mem_d;
      busy_q    <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_mem_q <= last_mem_d;
`endif
    end
  end

  assign bus.Mux_Sel = mux_sel_q;
  assign bus.Mem_En  = mem_en_q;
  assign bus.Mem_We  = mem_we_q;
  assign bus.Gnt_IF  = gnt_if_q;
  assign bus.Gnt_MEM = gnt_mem_q;
  assign bus.Ack_IF  = ack_if_q;
  assign bus.Ack_MEM = ack_mem_q;
  assign bus.Busy    = busy_q;
  assign fsm_state   = (state_q == ACCESS);

endmodule
